// File: rtl/dist_matrix_sched.sv
// Sequencer that streams every unordered city pair (i<j) through the pipelined
// distance unit, one pair per clock, and issues the matching distance-table writes.
module dist_matrix_sched #(
    parameter int N_MAX  = 32,
    parameter int IDX_W  = 5,
    parameter int LAT    = 11,
    parameter int DIST_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [IDX_W:0]    n_cities,
    output logic              busy,
    output logic              done,
    output logic [IDX_W-1:0]  coord_addr_a,
    output logic [IDX_W-1:0]  coord_addr_b,
    input  logic [7:0]        coord_xa,
    input  logic [7:0]        coord_ya,
    input  logic [7:0]        coord_xb,
    input  logic [7:0]        coord_yb,
    output logic [7:0]        dist_x1,
    output logic [7:0]        dist_y1,
    output logic [7:0]        dist_x2,
    output logic [7:0]        dist_y2,
    input  logic [DIST_W-1:0] dist_res,
    output logic              wr_en,
    output logic [IDX_W-1:0]  wr_i,
    output logic [IDX_W-1:0]  wr_j,
    output logic [DIST_W-1:0] wr_data
);

    localparam int CW = IDX_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]       state;
    logic [CW-1:0]    n_q;
    logic [CW-1:0]    i_q;
    logic [CW-1:0]    j_q;
    logic [CW-1:0]    n_clamp;
    logic             row_end;
    logic             last_pair;
    logic             issue;
    logic             drain_last;

    logic [LAT:0]     pipe_v;
    logic [IDX_W-1:0] pipe_i [LAT+1];
    logic [IDX_W-1:0] pipe_j [LAT+1];

    always_comb begin
        n_clamp    = (n_cities > CW'(N_MAX)) ? CW'(N_MAX) : n_cities;
        row_end    = (j_q == n_q - CW'(1));
        last_pair  = row_end && (i_q == n_q - CW'(2));
        issue      = (state == S_ISSUE);
        // The final write is in the last stage with nothing behind it.
        drain_last = pipe_v[LAT] && (pipe_v[LAT-1:0] == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            n_q   <= '0;
            i_q   <= '0;
            j_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_q   <= n_clamp;
                        i_q   <= '0;
                        j_q   <= CW'(1);
                        state <= (n_clamp >= CW'(2)) ? S_ISSUE : S_DONE;
                    end
                end
                S_ISSUE: begin
                    if (last_pair) begin
                        state <= S_DRAIN;
                    end else if (row_end) begin
                        i_q <= i_q + CW'(1);
                        j_q <= i_q + CW'(2);
                    end else begin
                        j_q <= j_q + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_last) state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Stage s holds the pair whose coordinates entered the distance unit s cycles ago.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_v <= '0;
            for (int unsigned s = 0; s <= LAT; s++) begin
                pipe_i[s] <= '0;
                pipe_j[s] <= '0;
            end
        end else begin
            pipe_v    <= {pipe_v[LAT-1:0], issue};
            pipe_i[0] <= i_q[IDX_W-1:0];
            pipe_j[0] <= j_q[IDX_W-1:0];
            for (int unsigned s = 1; s <= LAT; s++) begin
                pipe_i[s] <= pipe_i[s-1];
                pipe_j[s] <= pipe_j[s-1];
            end
        end
    end

    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);
    assign coord_addr_a = i_q[IDX_W-1:0];
    assign coord_addr_b = j_q[IDX_W-1:0];
    assign dist_x1      = coord_xa;
    assign dist_y1      = coord_ya;
    assign dist_x2      = coord_xb;
    assign dist_y2      = coord_yb;
    assign wr_en        = pipe_v[LAT];
    assign wr_i         = pipe_i[LAT];
    assign wr_j         = pipe_j[LAT];
    assign wr_data      = dist_res;

endmodule

// File: tb/tb_dist_matrix_sched.sv
// Randomized bench for dist_matrix_sched: models the coordinate RAM and distance
// unit, and checks write order, values and timing against an expected pair list.
module tb_dist_matrix_sched;

    localparam int N_MAX  = 32;
    localparam int IDX_W  = 5;
    localparam int LAT    = 11;
    localparam int DIST_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [IDX_W:0]    n_cities = '0;
    logic              busy, done;
    logic [IDX_W-1:0]  coord_addr_a, coord_addr_b;
    logic [7:0]        coord_xa = '0, coord_ya = '0, coord_xb = '0, coord_yb = '0;
    logic [7:0]        dist_x1, dist_y1, dist_x2, dist_y2;
    logic [DIST_W-1:0] dist_res;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_i, wr_j;
    logic [DIST_W-1:0] wr_data;

    dist_matrix_sched #(
        .N_MAX (N_MAX),
        .IDX_W (IDX_W),
        .LAT   (LAT),
        .DIST_W(DIST_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .n_cities(n_cities),
        .busy(busy), .done(done),
        .coord_addr_a(coord_addr_a), .coord_addr_b(coord_addr_b),
        .coord_xa(coord_xa), .coord_ya(coord_ya), .coord_xb(coord_xb), .coord_yb(coord_yb),
        .dist_x1(dist_x1), .dist_y1(dist_y1), .dist_x2(dist_x2), .dist_y2(dist_y2),
        .dist_res(dist_res),
        .wr_en(wr_en), .wr_i(wr_i), .wr_j(wr_j), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int cnt   = 0;
    int k_edge;

    logic [7:0]  cx [N_MAX];
    logic [7:0]  cy [N_MAX];
    logic [31:0] dpipe [LAT];

    int wq_t[$], wq_i[$], wq_j[$];
    int wq_d[$];
    int done_m, done_cnt, busy_cnt, busy_first, post_low;

    always @(posedge clk) cnt <= cnt + 1;

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Coordinate RAM (1-cycle read) and fixed-latency distance unit.
    always @(posedge clk) begin
        coord_xa <= cx[coord_addr_a];
        coord_ya <= cy[coord_addr_a];
        coord_xb <= cx[coord_addr_b];
        coord_yb <= cy[coord_addr_b];
        dpipe[0] <= 32'(isqrt((int'(dist_x1) - int'(dist_x2)) * (int'(dist_x1) - int'(dist_x2)) +
                              (int'(dist_y1) - int'(dist_y2)) * (int'(dist_y1) - int'(dist_y2))));
        for (int s = 1; s < LAT; s++) dpipe[s] <= dpipe[s-1];
    end
    assign dist_res = dpipe[LAT-1];

    function automatic int ref_dist(input int a, input int b);
        real dx, dy;
        dx = real'(int'(cx[a])) - real'(int'(cx[b]));
        dy = real'(int'(cy[a])) - real'(int'(cy[b]));
        return $rtoi($floor($sqrt(dx * dx + dy * dy)));
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic random_coords();
        int ok;
        for (int a = 0; a < N_MAX; a++) begin
            do begin
                cx[a] = 8'($urandom);
                cy[a] = 8'($urandom);
                ok = 1;
                for (int b = 0; b < a; b++)
                    if (cx[a] == cx[b] && cy[a] == cy[b]) ok = 0;
            end while (ok == 0);
        end
    endtask

    task automatic launch(input int n);
        @(negedge clk);
        start    = 1'b1;
        n_cities = (IDX_W+1)'(n);
        @(posedge clk);
        #1;
        k_edge   = cnt;
        start    = 1'b0;
        n_cities = (IDX_W+1)'($urandom);
    endtask

    // m is the spec cycle offset: m=1 is the cycle right after the start edge.
    task automatic collect(input string tag, input int rp_m, input int rp_n);
        int m;
        int got_done = 0;
        wq_t.delete(); wq_i.delete(); wq_j.delete(); wq_d.delete();
        done_m = -1; done_cnt = 0; busy_cnt = 0; busy_first = -1; post_low = 0;
        for (int c = 0; c < 700 && got_done == 0; c++) begin
            @(negedge clk);
            m = cnt - k_edge + 1;
            if (m == rp_m) begin
                start = 1'b1;
                n_cities = (IDX_W+1)'(rp_n);
            end else if (m == rp_m + 1) begin
                start = 1'b0;
            end
            if (wr_en) begin
                wq_t.push_back(m);
                wq_i.push_back(int'(wr_i));
                wq_j.push_back(int'(wr_j));
                wq_d.push_back(int'(wr_data));
            end
            if (busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = m;
            end
            if (done) begin
                done_cnt++;
                done_m = m;
                got_done = 1;
            end
        end
        if (got_done == 0) check({tag, "_timeout"}, 0, 1);
        @(negedge clk);
        post_low = (!done && !busy && !wr_en) ? 1 : 0;
    endtask

    task automatic check_run(input string tag, input int n_eff);
        int p = (n_eff >= 2) ? n_eff * (n_eff - 1) / 2 : 0;
        int idx = 0;
        check({tag, "_writes"}, wq_t.size(), p);
        for (int a = 0; a < n_eff - 1; a++) begin
            for (int b = a + 1; b < n_eff; b++) begin
                if (idx < wq_t.size()) begin
                    check($sformatf("%s_w%0d_i", tag, idx), wq_i[idx], a);
                    check($sformatf("%s_w%0d_j", tag, idx), wq_j[idx], b);
                    check($sformatf("%s_w%0d_data", tag, idx), wq_d[idx], ref_dist(a, b));
                    check($sformatf("%s_w%0d_cycle", tag, idx), wq_t[idx], LAT + 2 + idx);
                end
                idx++;
            end
        end
        check({tag, "_done_cycle"}, done_m, (p > 0) ? LAT + 2 + p : 1);
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_busy_first"}, busy_first, 1);
        check({tag, "_busy_cycles"}, busy_cnt, (p > 0) ? LAT + 2 + p : 1);
        check({tag, "_after_done_idle"}, post_low, 1);
    endtask

    initial begin
        int wr_seen;
        int max_j;
        int exp_d [6];
        for (int a = 0; a < N_MAX; a++) begin
            cx[a] = '0;
            cy[a] = '0;
        end
        for (int s = 0; s < LAT; s++) dpipe[s] = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_wr_ij", int'({wr_i, wr_j}), 0);
        check("rst_addr", int'({coord_addr_a, coord_addr_b}), 0);
        rst_n = 1'b1;

        // 1: hand-checked 4-city example
        cx[0] = 8'd0; cy[0] = 8'd0;
        cx[1] = 8'd3; cy[1] = 8'd4;
        cx[2] = 8'd0; cy[2] = 8'd8;
        cx[3] = 8'd6; cy[3] = 8'd8;
        launch(4);
        collect("t1", 0, 0);
        check_run("t1", 4);
        exp_d = '{5, 8, 10, 5, 5, 6};
        for (int w = 0; w < 6; w++)
            if (w < wq_d.size()) check($sformatf("t1_const%0d", w), wq_d[w], exp_d[w]);

        // 2: degenerate counts
        launch(1);
        collect("t2a", 0, 0);
        check_run("t2a", 1);
        launch(0);
        collect("t2b", 0, 0);
        check_run("t2b", 0);

        // 3: full table
        random_coords();
        launch(32);
        collect("t3", 0, 0);
        check_run("t3", 32);

        // 4: second start during ISSUE is ignored
        random_coords();
        launch(10);
        collect("t4", 5, 6);
        check_run("t4", 10);

        // 5: reset mid-run
        launch(8);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_busy", int'(busy), 0);
        check("t5_done", int'(done), 0);
        check("t5_wr_en", int'(wr_en), 0);
        check("t5_wr_ij", int'({wr_i, wr_j}), 0);
        check("t5_addr", int'({coord_addr_a, coord_addr_b}), 0);
        wr_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (wr_en || busy) wr_seen++;
        end
        check("t5_quiet_after_reset", wr_seen, 0);
        launch(3);
        collect("t5", 0, 0);
        check_run("t5", 3);

        // 6: oversize count clamps to N_MAX
        random_coords();
        launch(40);
        collect("t6", 0, 0);
        check_run("t6", 32);
        max_j = 0;
        foreach (wq_j[w]) if (wq_j[w] > max_j) max_j = wq_j[w];
        check("t6_max_index", max_j, 31);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
